// File: rtl/jpeg_frame_sched.sv
// jpeg_frame_sched: frame-level round-robin scheduler sharing one JPEG decoder between two byte sources.
// Define JPEG_SCHED_STATS_EN to implement the frame_cnt_o / timeout_cnt_o statistics counters.
module jpeg_frame_sched #(
  parameter int IDLE_HOLD  = 16,
  parameter int RST_CYCLES = 8,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 src0_valid_i,
  input  logic [7:0]           src0_data_i,
  input  logic                 src0_last_i,
  output logic                 src0_accept_o,
  input  logic                 src1_valid_i,
  input  logic [7:0]           src1_data_i,
  input  logic                 src1_last_i,
  output logic                 src1_accept_o,
  output logic                 dec_valid_o,
  output logic [7:0]           dec_data_o,
  output logic                 dec_last_o,
  input  logic                 dec_accept_i,
  input  logic                 dec_idle_i,
  output logic                 dec_rst_o,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 grant_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 timeout_o,
  output logic [15:0]          frame_cnt_o,
  output logic [7:0]           timeout_cnt_o
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STREAM  = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [7:0] HOLD      = 8'(IDLE_HOLD);
  localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES - 1);

  logic [2:0]           r_state;
  logic                 r_grant;
  logic                 r_any;
  logic                 r_from_stream;
  logic [TIMEOUT_W-1:0] r_wd;
  logic [7:0]           r_idle_cnt;
  logic [7:0]           r_rst_cnt;

  logic                 w_sv, w_sl, w_stream, w_drain, w_flush, w_hs, w_hs_last, w_done, w_timeout, w_acc;
  logic [7:0]           w_sd;
  logic [TIMEOUT_W-1:0] w_wd_next;

  assign w_sv      = r_grant ? src1_valid_i : src0_valid_i;
  assign w_sd      = r_grant ? src1_data_i : src0_data_i;
  assign w_sl      = r_grant ? src1_last_i : src0_last_i;
  assign w_stream  = r_state == S_STREAM;
  assign w_drain   = r_state == S_DRAIN;
  assign w_flush   = r_state == S_FLUSH;
  assign w_acc     = w_stream ? dec_accept_i : w_flush;
  assign w_hs      = w_sv & w_acc;
  assign w_hs_last = w_hs & w_sl;
  assign w_done    = w_drain & (r_idle_cnt == HOLD);
  // a handshake clears the count, so a last handshake can never coincide with a timeout
  assign w_wd_next = ((w_stream & ~w_hs) | w_drain) ? r_wd + 1'b1 : '0;
  assign w_timeout = (w_stream | (w_drain & ~w_done)) & (timeout_i != '0) & (w_wd_next == timeout_i);

  assign dec_valid_o   = w_stream & w_sv;
  assign dec_data_o    = w_stream ? w_sd : 8'd0;
  assign dec_last_o    = w_stream & w_sl;
  assign src0_accept_o = w_acc & ~r_grant;
  assign src1_accept_o = w_acc & r_grant;
  assign dec_rst_o     = r_state == S_RECOVER;
  assign grant_o       = r_grant;
  assign busy_o        = r_state != S_IDLE;
  assign frame_done_o  = w_done;
  assign timeout_o     = w_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_grant       <= 1'b0;
      r_any         <= 1'b0;
      r_from_stream <= 1'b0;
      r_wd          <= '0;
      r_idle_cnt    <= 8'd0;
      r_rst_cnt     <= 8'd0;
    end else begin
      r_wd       <= w_wd_next;
      r_idle_cnt <= (w_drain & dec_idle_i) ? ((r_idle_cnt == HOLD) ? HOLD : r_idle_cnt + 8'd1) : 8'd0;
      r_rst_cnt  <= (r_state == S_RECOVER) ? r_rst_cnt + 8'd1 : 8'd0;
      case (r_state)
        S_IDLE:
          if (src0_valid_i | src1_valid_i) begin
            // the first contested grant after reset goes to src0
            r_grant <= (src0_valid_i & src1_valid_i) ? (r_any & ~r_grant) : src1_valid_i;
            r_any   <= 1'b1;
            r_state <= S_STREAM;
          end
        S_STREAM:
          if (w_hs_last) r_state <= S_DRAIN;
          else if (w_timeout) begin
            r_state       <= S_RECOVER;
            r_from_stream <= 1'b1;
          end
        S_DRAIN:
          if (w_done) r_state <= S_IDLE;
          else if (w_timeout) begin
            r_state       <= S_RECOVER;
            r_from_stream <= 1'b0;
          end
        S_RECOVER:
          if (r_rst_cnt == RST_LAST) r_state <= r_from_stream ? S_FLUSH : S_IDLE;
        S_FLUSH:
          if (w_hs_last) r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

`ifdef JPEG_SCHED_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_timeout_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame_cnt   <= 16'd0;
      r_timeout_cnt <= 8'd0;
    end else begin
      if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_timeout) r_timeout_cnt <= r_timeout_cnt + 8'd1;
    end
  end
  assign frame_cnt_o   = r_frame_cnt;
  assign timeout_cnt_o = r_timeout_cnt;
`else
  assign frame_cnt_o   = 16'd0;
  assign timeout_cnt_o = 8'd0;
`endif
endmodule

// File: tb/tb_jpeg_frame_sched.sv
// tb_jpeg_frame_sched: scoreboard bench for jpeg_frame_sched with random and directed frame traffic.
module tb_jpeg_frame_sched;
`ifdef JPEG_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        src0_valid_i = 1'b0, src0_last_i = 1'b0, src1_valid_i = 1'b0, src1_last_i = 1'b0;
  logic [7:0]  src0_data_i = 8'd0, src1_data_i = 8'd0;
  logic        dec_accept_i = 1'b1, dec_idle_i = 1'b1;
  logic [23:0] timeout_i = 24'd0;
  logic        src0_accept_o, src1_accept_o, dec_valid_o, dec_last_o, dec_rst_o;
  logic        grant_o, busy_o, frame_done_o, timeout_o;
  logic [7:0]  dec_data_o, timeout_cnt_o;
  logic [15:0] frame_cnt_o;

  logic [8:0] src_q[2][$];
  logic [8:0] exp_q[2][$];
  int  pop_cnt[2], stop_after[2], src_hs_cyc[2];
  bit  hs[2];
  int  gap_pct = 0, acc_mode = 0, idle_dly = 5;
  bit  stuck = 1'b0, prev_rst = 1'b0;
  int  cyc = 0, last_c = -1000, fd_cnt = 0, to_cnt = 0, rst_hi = 0, rst_start = 0, to_cyc = 0, fd_cyc = 0;
  bit  grant_log[$];
  int  checks = 0, errors = 0, exp_fc = 0, exp_tc = 0;

  jpeg_frame_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .src0_valid_i(src0_valid_i), .src0_data_i(src0_data_i), .src0_last_i(src0_last_i), .src0_accept_o(src0_accept_o),
    .src1_valid_i(src1_valid_i), .src1_data_i(src1_data_i), .src1_last_i(src1_last_i), .src1_accept_o(src1_accept_o),
    .dec_valid_o(dec_valid_o), .dec_data_o(dec_data_o), .dec_last_o(dec_last_o),
    .dec_accept_i(dec_accept_i), .dec_idle_i(dec_idle_i), .dec_rst_o(dec_rst_o), .timeout_i(timeout_i),
    .grant_o(grant_o), .busy_o(busy_o), .frame_done_o(frame_done_o), .timeout_o(timeout_o),
    .frame_cnt_o(frame_cnt_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int s, input int len, input int deliver);
    for (int i = 0; i < len; i++) begin
      logic [8:0] b;
      b = {i == len - 1, 8'($urandom)};
      src_q[s].push_back(b);
      if (i < deliver) exp_q[s].push_back(b);
    end
  endtask

  task automatic wait_drained(input string name, input int max);
    int n = 0;
    while (n < max && (src_q[0].size() != 0 || src_q[1].size() != 0 || busy_o)) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_drain_bound"}, 64'(n < max), 64'd1);
    check({name, "_scoreboard_empty"}, 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
  endtask

  task automatic chk_stats(input string name);
    check({name, "_frame_cnt"}, 64'(frame_cnt_o), STATS ? 64'(exp_fc) : 64'd0);
    check({name, "_timeout_cnt"}, 64'(timeout_cnt_o), STATS ? 64'(exp_tc) : 64'd0);
  endtask

  // source and decoder behaviour, updated just after each rising edge
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      for (int s = 0; s < 2; s++) begin
        if (hs[s] && src_q[s].size() > 0) begin
          void'(src_q[s].pop_front());
          pop_cnt[s]++;
        end
        hs[s] = 1'b0;
      end
      src0_valid_i = src_q[0].size() > 0 && pop_cnt[0] != stop_after[0] && $urandom_range(99) >= gap_pct;
      src1_valid_i = src_q[1].size() > 0 && pop_cnt[1] != stop_after[1] && $urandom_range(99) >= gap_pct;
      {src0_last_i, src0_data_i} = src_q[0].size() > 0 ? src_q[0][0] : 9'd0;
      {src1_last_i, src1_data_i} = src_q[1].size() > 0 ? src_q[1][0] : 9'd0;
      dec_accept_i = acc_mode == 0 ? 1'b1 : acc_mode == 1 ? ~dec_accept_i : 1'($urandom_range(1));
      dec_idle_i = !stuck && (cyc + 1 >= last_c + idle_dly);
    end
  end

  // monitor: pops the scoreboard on every decoder handshake
  always @(negedge clk_i) begin
    cyc++;
    if (rst_ni) begin
      hs[0] = src0_valid_i & src0_accept_o;
      hs[1] = src1_valid_i & src1_accept_o;
      if (hs[0]) src_hs_cyc[0] = cyc;
      if (hs[1]) src_hs_cyc[1] = cyc;
      if (grant_o ? src0_accept_o : src1_accept_o) begin
        errors++;
        $display("FAIL ungranted_accept: grant=%0d acc0=%0d acc1=%0d", grant_o, src0_accept_o, src1_accept_o);
      end
      if (dec_valid_o && dec_accept_i) begin
        if (dec_last_o) last_c = cyc;
        if (exp_q[grant_o].size() == 0) begin
          errors++;
          $display("FAIL dec_byte: got %0d from src%0d expected no byte", {dec_last_o, dec_data_o}, grant_o);
        end else check("dec_byte", 64'({dec_last_o, dec_data_o}), 64'(exp_q[grant_o].pop_front()));
      end
      if (frame_done_o) begin
        fd_cnt++;
        fd_cyc = cyc;
        grant_log.push_back(grant_o);
      end
      if (timeout_o) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (dec_rst_o) begin
        if (!prev_rst) rst_start = cyc;
        rst_hi++;
      end
      prev_rst = dec_rst_o;
    end
  end

  initial begin
    int n, t0, r0, fd0, lat;
    stop_after[0] = -1;
    stop_after[1] = -1;
    repeat (3) @(negedge clk_i);
    check("reset_outputs", 64'({dec_valid_o, dec_last_o, dec_data_o, src0_accept_o, src1_accept_o, dec_rst_o,
                              grant_o, busy_o, frame_done_o, timeout_o, frame_cnt_o, timeout_cnt_o}), 64'd0);
    rst_ni = 1'b1;

    // single 100-byte frame on src0, decoder idle from 5 cycles after last
    idle_dly = 5;
    push_frame(0, 100, 100);
    exp_fc++;
    wait_drained("t1", 2000);
    check("t1_done_latency", 64'(fd_cyc - last_c), 64'd21);
    check("t1_frames", 64'(fd_cnt), 64'd1);
    check("t1_grant", 64'(grant_o), 64'd0);
    chk_stats("t1");

    // contention: src0 was last granted, so src1 wins first
    grant_log.delete();
    push_frame(0, 10, 10);
    push_frame(1, 10, 10);
    push_frame(1, 10, 10);
    exp_fc += 3;
    wait_drained("t2", 1000);
    check("t2_frames", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() == 3) check("t2_grant_seq", 64'({grant_log[0], grant_log[1], grant_log[2]}), 64'b101);
    chk_stats("t2");

    // backpressure: accept toggles every cycle
    acc_mode = 1;
    timeout_i = 24'd100;
    t0 = to_cnt;
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(5, 30);
      push_frame(i % 2, n, n);
      exp_fc++;
    end
    wait_drained("t3", 2000);
    check("t3_no_timeout", 64'(to_cnt - t0), 64'd0);
    acc_mode = 0;

    // source stalls after byte 20 of 50
    timeout_i = 24'd50;
    pop_cnt[0] = 0;
    stop_after[0] = 20;
    push_frame(0, 50, 20);
    exp_tc++;
    t0 = to_cnt;
    r0 = rst_hi;
    fd0 = fd_cnt;
    n = 0;
    while (to_cnt == t0 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check("t4_timeout_seen", 64'(to_cnt - t0), 64'd1);
    lat = to_cyc - src_hs_cyc[0];
    check("t4_timeout_latency", 64'(lat), 64'd50);
    stop_after[0] = -1;
    wait_drained("t4", 500);
    check("t4_rst_cycles", 64'(rst_hi - r0), 64'd8);
    check("t4_rst_start", 64'(rst_start - to_cyc), 64'd1);
    check("t4_flushed_bytes", 64'(pop_cnt[0]), 64'd50);
    check("t4_no_done", 64'(fd_cnt - fd0), 64'd0);
    chk_stats("t4");

    // decoder never goes idle after last
    timeout_i = 24'd200;
    stuck = 1'b1;
    r0 = rst_hi;
    fd0 = fd_cnt;
    push_frame(1, 10, 10);
    exp_tc++;
    wait_drained("t5", 1000);
    check("t5_timeout_latency", 64'(to_cyc - last_c), 64'd200);
    check("t5_rst_cycles", 64'(rst_hi - r0), 64'd8);
    check("t5_rst_start", 64'(rst_start - to_cyc), 64'd1);
    check("t5_no_done", 64'(fd_cnt - fd0), 64'd0);
    chk_stats("t5");
    stuck = 1'b0;

    // random traffic
    fd0 = fd_cnt;
    t0 = exp_fc;
    for (int b = 0; b < 8; b++) begin
      gap_pct = 20;
      acc_mode = 2;
      idle_dly = $urandom_range(1, 8);
      timeout_i = $urandom_range(1) ? 24'd0 : 24'd3000;
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        n = $urandom_range(1, 24);
        push_frame($urandom_range(1), n, n);
        exp_fc++;
      end
      wait_drained("rand", 3000);
    end
    check("rand_frames", 64'(fd_cnt - fd0), 64'(exp_fc - t0));
    chk_stats("rand");

    // reset in the middle of a frame
    gap_pct = 0;
    acc_mode = 0;
    timeout_i = 24'd0;
    pop_cnt[0] = 0;
    push_frame(0, 20, 20);
    n = 0;
    while (pop_cnt[0] < 7 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_async_outputs", 64'({dec_valid_o, dec_last_o, dec_data_o, src0_accept_o, src1_accept_o, dec_rst_o,
                                 grant_o, busy_o, frame_done_o, timeout_o, frame_cnt_o, timeout_cnt_o}), 64'd0);
    for (int s = 0; s < 2; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
      hs[s] = 1'b0;
      pop_cnt[s] = 0;
    end
    exp_fc = 0;
    exp_tc = 0;
    repeat (3) @(negedge clk_i);
    chk_stats("t6_in_reset");
    fd0 = fd_cnt;
    push_frame(0, 8, 8);
    push_frame(1, 8, 8);
    exp_fc = 2;
    rst_ni = 1'b1;
    n = 0;
    while (!busy_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("t6_busy_after_release", 64'(busy_o), 64'd1);
    check("t6_first_grant", 64'(grant_o), 64'd0);
    wait_drained("t6", 1000);
    check("t6_frames", 64'(fd_cnt - fd0), 64'd2);
    chk_stats("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete, errors %0d", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
